multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised N-channel clock divider, next generation of the UART clock divider. Each channel produces a one-cycle `tick` strobe and a toggling `clk_div` output from one system clock. Each channel has its own integer divisor plus an optional fractional part, a per-channel enable, and glitch-free reprogramming at period boundaries. It feeds UART TX/RX and other slow peripherals that need independent, accurately averaged rates.

## Interface
- `CHANNELS`, 2: number of independent divider channels (1..16).
- `INT_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor; fraction = `div_frac` / 2^FRAC_W.
- `DEFAULT_DIV`, 16: reset value of every channel's integer divisor (frac resets to 0).
- `CH_W` (localparam): max(1, clog2(CHANNELS)).

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in CHANNELS: per-channel enable, level-sensitive.
- `div_wr` in 1: one-cycle divisor write strobe.
- `div_ch` in CH_W: channel index for the write; values ≥ CHANNELS are ignored.
- `div_int` in INT_W: integer divisor N; 0 is treated as 1.
- `div_frac` in FRAC_W: fractional divisor F.
- `tick` out CHANNELS: registered one-cycle strobe per channel period.
- `clk_div` out CHANNELS: registered; toggles on every tick (output period = 2 tick periods).
- `pending` out CHANNELS: shadow divisor written but not yet active.

## Operation
- Per channel registers: active {N, F}, shadow {N, F}, `pending`, down-counter `cnt` (INT_W bits), accumulator `acc` (FRAC_W bits), `tick`, `clk_div`.
- Reset: active and shadow N = DEFAULT_DIV (0 treated as 1), F = 0. `cnt` = N-1. `acc`, `tick`, `clk_div` and `pending` are all 0.
- `en` low: `cnt` <= N-1, `acc` <= 0, `tick` <= 0, `clk_div` <= 0.
- `en` high, `cnt` != 0: `cnt` <= `cnt`-1, `tick` <= 0.
- `en` high, `cnt` == 0 (tick edge): `tick` <= 1 and `clk_div` <= ~`clk_div`.
  - If `pending` is set: active <= shadow, `pending` <= 0, `acc` <= 0, `cnt` <= newN-1.
  - Otherwise: {c, `acc`} <= `acc` + F, with c the carry out of FRAC_W bits; `cnt` <= N-1+c.
- Result: tick spacing is N or N+1 cycles, with average N + F/2^FRAC_W.
- Write with `div_wr` high to a valid `div_ch`:
  - Shadow <= {`div_int`, `div_frac`} and `pending` <= 1.
  - A later write before apply overwrites the shadow; the last one wins.
- Write to a channel whose `en` is low: active <= written value directly and `pending` stays 0. The new N is used for the `cnt` reload on the next edge.
- Write on the same edge as that channel's tick edge: the tick edge applies the previous shadow (if pending). The new write lands in the shadow with `pending`=1 and applies at the following tick.
- `en` deasserted mid-period: counting aborts at once and `clk_div` returns to 0. A pending shadow stays pending until the next tick edge; a write while `en` is low applies immediately as above.
- Channels are fully independent; only the write port is shared.

## Timing
- With `en` first sampled high at edge E and F=0, `tick` is high after edge E+N-1, then every N cycles.
- N=1: `tick` is high every cycle, and `clk_div` toggles every cycle (clk/2).
- `tick` is exactly one cycle wide whenever N ≥ 2 or a carry extends the period.
- `pending` rises the cycle after `div_wr` and falls after the tick edge that applies the shadow.
- No combinational path from inputs to outputs.

## Configuration
- `MULTI_CLKDIV_FRAC_EN` defined: fractional accumulator present, behaviour as above.
- Not defined: `div_frac` is ignored, there is no `acc` and no shadow F, and every period is exactly N cycles. All ports remain, so instantiations are unchanged.

## Test plan
- Reset with DEFAULT_DIV=16, then `en`[0]=1 at edge E -> `tick`[0] high after E+15, E+31, …. `clk_div`[0] 0→1 at E+15 and 1→0 at E+31.
- Frac build, ch0 disabled, write N=3, F=8 (FRAC_W=4), then enable -> tick spacing alternates 3,4,3,4. Over 16 ticks: 56 cycles. `pending` never set.
- Ch1 running N=4; write N=2 mid-period -> `pending`[1]=1 until the next tick edge. That tick keeps 4-cycle spacing; thereafter spacing is 2 and `pending`[1]=0.
- Write coincident with ch0's tick edge -> the old/previous shadow is used for the next period. The new value applies one tick later and `pending`[0] stays high in between.
- `div_int`=0 -> behaves as N=1: `tick` high every cycle, `clk_div` = clk/2. `div_ch`=CHANNELS -> no register changes.
- Drop `reset_n` mid-period and drop `en` mid-period -> all outputs 0 immediately/next edge respectively. After re-enable, the first tick comes N cycles later.

Source files
------------

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_clock_divider
// Brief    : N-channel clock divider. Each channel emits a one-cycle tick and
//            a toggling clk_div, with its own integer divisor, optional
//            fractional divisor, enable, and shadowed reprogramming that is
//            applied only at period boundaries.
//            Optional feature macro: MULTI_CLKDIV_FRAC_EN (fractional
//            accumulator; when undefined div_frac is ignored).
// Revision : 1.0 - initial release
// ============================================================================
module multi_clock_divider #(
    parameter  int CHANNELS    = 2,
    parameter  int INT_W       = 16,
    parameter  int FRAC_W      = 4,
    parameter  int DEFAULT_DIV = 16,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                div_wr,
    input  logic [CH_W-1:0]     div_ch,
    input  logic [INT_W-1:0]    div_int,
    input  logic [FRAC_W-1:0]   div_frac,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [INT_W-1:0] C_ONE     = INT_W'(1);
    localparam logic [INT_W-1:0] C_DEF_RAW = INT_W'(DEFAULT_DIV);
    // A divisor of 0 is meaningless; it behaves exactly like 1.
    localparam logic [INT_W-1:0] C_DEF_N   = (C_DEF_RAW == '0) ? C_ONE : C_DEF_RAW;

    // Normalised write value shared by all channels.
    logic [INT_W-1:0] w_wr_n;
    assign w_wr_n = (div_int == '0) ? C_ONE : div_int;

`ifndef MULTI_CLKDIV_FRAC_EN
    // div_frac stays on the port list so instantiations do not change.
    logic w_unused_frac;
    assign w_unused_frac = ^div_frac;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [INT_W-1:0] r_act_n;
        logic [INT_W-1:0] r_shd_n;
        logic [INT_W-1:0] r_cnt;
        logic             r_pend;
        logic             r_tick;
        logic             r_clk_div;
        logic             w_wr_hit;
        logic             w_cnt_zero;
        logic [INT_W-1:0] w_carry;

        // Indices >= CHANNELS never match any channel, so they are ignored.
        assign w_wr_hit   = div_wr && (div_ch == CH_W'(gi));
        assign w_cnt_zero = (r_cnt == '0);

`ifdef MULTI_CLKDIV_FRAC_EN
        logic [FRAC_W-1:0] r_act_f;
        logic [FRAC_W-1:0] r_shd_f;
        logic [FRAC_W-1:0] r_acc;
        logic [FRAC_W:0]   w_acc_sum;

        // Carry out of the fraction stretches the next period by one cycle.
        assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_f};
        assign w_carry   = {{(INT_W-1){1'b0}}, w_acc_sum[FRAC_W]};

        // Fractional state: active/shadow fraction and phase accumulator.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_act_f <= '0;
                r_shd_f <= '0;
                r_acc   <= '0;
            end else if (!en[gi]) begin
                r_acc <= '0;
                if (w_wr_hit) begin
                    r_act_f <= div_frac;
                    r_shd_f <= div_frac;
                end
            end else begin
                if (w_cnt_zero) begin
                    if (r_pend) begin
                        r_act_f <= r_shd_f;
                        r_acc   <= '0;
                    end else begin
                        r_acc <= w_acc_sum[FRAC_W-1:0];
                    end
                end
                if (w_wr_hit) begin
                    r_shd_f <= div_frac;
                end
            end
        end
`else
        assign w_carry = '0;
`endif

        // Integer divider: counter, tick/clk_div generation, shadow handling.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_act_n   <= C_DEF_N;
                r_shd_n   <= C_DEF_N;
                r_cnt     <= C_DEF_N - C_ONE;
                r_pend    <= 1'b0;
                r_tick    <= 1'b0;
                r_clk_div <= 1'b0;
            end else if (!en[gi]) begin
                // Reload uses the divisor active before this edge's write.
                r_cnt     <= r_act_n - C_ONE;
                r_tick    <= 1'b0;
                r_clk_div <= 1'b0;
                if (w_wr_hit) begin
                    // Idle channel: take the value at once; the latest write
                    // supersedes any shadow still waiting for a tick edge.
                    r_act_n <= w_wr_n;
                    r_shd_n <= w_wr_n;
                    r_pend  <= 1'b0;
                end
            end else begin
                if (w_cnt_zero) begin
                    r_tick    <= 1'b1;
                    r_clk_div <= ~r_clk_div;
                    if (r_pend) begin
                        r_act_n <= r_shd_n;
                        r_pend  <= 1'b0;
                        r_cnt   <= r_shd_n - C_ONE;
                    end else begin
                        r_cnt <= r_act_n - C_ONE + w_carry;
                    end
                end else begin
                    r_cnt  <= r_cnt - C_ONE;
                    r_tick <= 1'b0;
                end
                // A write on the tick edge lands after the apply above, so it
                // stays pending for the following period.
                if (w_wr_hit) begin
                    r_shd_n <= w_wr_n;
                    r_pend  <= 1'b1;
                end
            end
        end

        assign tick[gi]    = r_tick;
        assign clk_div[gi] = r_clk_div;
        assign pending[gi] = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_clock_divider
// Brief    : Self-checking bench for multi_clock_divider: directed timing
//            sequences, a vector table for N=1 / invalid channel, and a
//            randomized run against a behavioural period model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int CH  = 3;
    localparam int IW  = 16;
    localparam int FW  = 4;
    localparam int DEF = 16;
    localparam int CW  = 2;
`ifdef MULTI_CLKDIV_FRAC_EN
    localparam int FRAC_ON = 1;
`else
    localparam int FRAC_ON = 0;
`endif

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic [CH-1:0] en       = '0;
    logic          div_wr   = 1'b0;
    logic [CW-1:0] div_ch   = '0;
    logic [IW-1:0] div_int  = '0;
    logic [FW-1:0] div_frac = '0;
    wire  [CH-1:0] tick;
    wire  [CH-1:0] clk_div;
    wire  [CH-1:0] pending;

    int errors = 0;
    int checks = 0;

    multi_clock_divider #(
        .CHANNELS    (CH),
        .INT_W       (IW),
        .FRAC_W      (FW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_int  (div_int),
        .div_frac (div_frac),
        .tick     (tick),
        .clk_div  (clk_div),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: each channel tracks the number of enabled edges
    // left until its next tick and a running fractional sum.
    // ------------------------------------------------------------------
    typedef struct {
        int n;  int f;  int sn;  int sf;
        int left;  int fsum;
        bit pend;  bit tk;  bit cd;
    } ch_t;

    ch_t m [CH];

    function automatic ch_t reset_ch();
        ch_t r;
        r.n = DEF; r.f = 0; r.sn = DEF; r.sf = 0;
        r.left = DEF; r.fsum = 0; r.pend = 0; r.tk = 0; r.cd = 0;
        return r;
    endfunction

    function automatic ch_t step_ch(input ch_t s, input bit e, input bit wr,
                                    input int wn, input int wf);
        ch_t r = s;
        if (!e) begin
            r.left = s.n; r.fsum = 0; r.tk = 0; r.cd = 0;
            if (wr) begin
                r.n = wn; r.f = wf; r.sn = wn; r.sf = wf; r.pend = 0;
            end
        end else begin
            r.left = s.left - 1;
            if (r.left == 0) begin
                r.tk = 1;
                r.cd = !s.cd;
                if (s.pend) begin
                    r.n = s.sn; r.f = s.sf; r.pend = 0; r.fsum = 0; r.left = s.sn;
                end else begin
                    r.fsum = s.fsum + s.f;
                    r.left = s.n + r.fsum / (1 << FW);
                    r.fsum = r.fsum % (1 << FW);
                end
            end else begin
                r.tk = 0;
            end
            if (wr) begin
                r.sn = wn; r.sf = wf; r.pend = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) m[i] <= reset_ch();
        end else begin
            for (int i = 0; i < CH; i++)
                m[i] <= step_ch(m[i], en[i], div_wr && (int'(div_ch) == i),
                                (div_int == 0) ? 1 : int'(div_int),
                                FRAC_ON ? int'(div_frac) : 0);
        end
    end

    function automatic logic [CH-1:0] mvec(input int sel);
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++)
            v[i] = (sel == 0) ? m[i].tk : (sel == 1) ? m[i].cd : m[i].pend;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write while the channel is idle, then leave one idle edge so the
    // counter reloads with the new divisor.
    task automatic cfg(input int ch, input int n, input int f);
        @(negedge clk);
        div_wr = 1'b1; div_ch = CW'(ch); div_int = IW'(n); div_frac = FW'(f);
        @(negedge clk);
        div_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tick(input int ch);
        int found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (tick[ch]) found = 1;
        end
        chk($sformatf("wait_tick_ch%0d", ch), found, 1);
    endtask

    typedef struct {
        logic        en2;
        logic        wr;
        logic [1:0]  ch;
        logic [15:0] n;
        logic        e_tick;
        logic        e_clk;
        logic        e_pend;
    } vec_t;

    vec_t tbl [7];
    int   iv [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first, ticks, last;
        bit pend_seen;

        // ch2 vectors: N=0 behaves as 1, writes to channel 3 are ignored.
        tbl[0] = '{1'b0, 1'b1, 2'd2, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 2'd3, 16'd7, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};

        // --- Reset state and default divisor timing -----------------------
        repeat (2) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_clkdiv", clk_div, 0);
        chk("rst_pending", pending, 0);
        reset_n = 1'b1;
        @(negedge clk);
        en[0] = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk($sformatf("def_tick_k%0d", k), tick[0], (k == 16 || k == 32));
            chk($sformatf("def_clkdiv_k%0d", k), clk_div[0], (k >= 16 && k < 32));
        end
        en[0] = 1'b0;

        // --- Fractional divisor N=3, F=8 ----------------------------------
        cfg(0, 3, 8);
        en[0] = 1'b1;
        t_first = -1; ticks = 0; last = -1; pend_seen = 0;
        for (int c = 1; c <= 120 && ticks < 17; c++) begin
            @(negedge clk);
            pend_seen |= pending[0];
            if (tick[0]) begin
                if (ticks == 0) t_first = c;
                else iv.push_back(c - last);
                last = c;
                ticks++;
            end
        end
        chk("frac_first_tick", t_first, 3);
        chk("frac_tick_count", ticks, 17);
        chk("frac_16_periods", last - t_first, FRAC_ON ? 56 : 48);
        chk("frac_iv0", (iv.size() > 0) ? iv[0] : -1, 3);
        chk("frac_iv1", (iv.size() > 1) ? iv[1] : -1, FRAC_ON ? 4 : 3);
        chk("frac_no_pending", pend_seen, 0);
        en[0] = 1'b0;

        // --- ch1 N=4, rewritten to N=2 mid-period --------------------------
        cfg(1, 4, 0);
        en[1] = 1'b1;
        wait_tick(1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("midwr_tick_k%0d", k), tick[1], (k == 4 || k == 6 || k == 8));
            chk($sformatf("midwr_pend_k%0d", k), pending[1], (k == 2 || k == 3));
            if (k == 1) begin div_wr = 1'b1; div_ch = 2'd1; div_int = 16'd2; div_frac = '0; end
            if (k == 2) div_wr = 1'b0;
        end
        en[1] = 1'b0;

        // --- Write coincident with ch0 tick edge ---------------------------
        cfg(0, 4, 0);
        en[0] = 1'b1;
        wait_tick(0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("coinc_tick_k%0d", k), tick[0], (k == 4 || k == 7 || k == 12));
            chk($sformatf("coinc_pend_k%0d", k), pending[0], (k >= 2 && k <= 6));
            if (k == 1) begin div_wr = 1'b1; div_ch = 2'd0; div_int = 16'd3; div_frac = '0; end
            if (k == 2) div_wr = 1'b0;
            if (k == 3) begin div_wr = 1'b1; div_int = 16'd5; end
            if (k == 4) div_wr = 1'b0;
        end
        en[0] = 1'b0;

        // --- Vector table on ch2 -------------------------------------------
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            en[2] = tbl[i].en2; div_wr = tbl[i].wr; div_ch = tbl[i].ch;
            div_int = tbl[i].n; div_frac = '0;
            @(negedge clk);
            chk($sformatf("tbl%0d_tick", i), tick[2], tbl[i].e_tick);
            chk($sformatf("tbl%0d_clkdiv", i), clk_div[2], tbl[i].e_clk);
            chk($sformatf("tbl%0d_pending", i), pending, {tbl[i].e_pend, 2'b00});
        end
        div_wr = 1'b0;

        // --- Enable dropped mid-period, then re-enable ---------------------
        cfg(0, 5, 0);
        en[0] = 1'b1;
        wait_tick(0);
        repeat (2) @(negedge clk);
        chk("endrop_clkdiv_before", clk_div[0], 1);
        en[0] = 1'b0;
        @(negedge clk);
        chk("endrop_tick", tick[0], 0);
        chk("endrop_clkdiv", clk_div[0], 0);
        en[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("reen_tick_k%0d", k), tick[0], (k == 5));
        end

        // --- Asynchronous reset mid-period ---------------------------------
        en[1] = 1'b1;
        div_wr = 1'b1; div_ch = 2'd1; div_int = 16'd9;
        @(negedge clk);
        div_wr = 1'b0;
        chk("arst_pending_before", pending[1], 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_clkdiv", clk_div, 0);
        chk("arst_pending", pending, 0);
        en = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // --- Randomized run against the model -------------------------------
        en = '1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            chk("rand_tick", tick, mvec(0));
            chk("rand_clkdiv", clk_div, mvec(1));
            chk("rand_pending", pending, mvec(2));
            for (int i = 0; i < CH; i++) begin
                if (en[i]) begin
                    if ($urandom_range(39) == 0) en[i] = 1'b0;
                end else begin
                    if ($urandom_range(4) == 0) en[i] = 1'b1;
                end
            end
            div_wr   = ($urandom_range(4) == 0);
            div_ch   = CW'($urandom_range(3));
            div_int  = IW'($urandom_range(6));
            div_frac = FW'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
